key_sched_ctrl: RTL and testbench

- Sequencer that drives the evolve_key AES-256 key expander and caches its output.
- On request it selects key1 or key2, pulses ks_load, then steps ks_round 0..NUM_RK-1.
- It captures each ks_out into a 15-entry round-key buffer.
- The round engine reads round keys from this buffer through a registered read port. A repeat request for the already-cached key skips re-expansion.

---
 rtl/key_sched_ctrl.sv | 166 ++++++++++++++++
 tb/tb_key_sched_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// Sequencer for the evolve_key AES-256 expander: issues ks_load / ks_round,
// captures each round key into a local buffer and serves registered reads from it.
module key_sched_ctrl #(
    parameter int NUM_RK = 15,
    parameter int KS_LAT = 1,
    parameter int KEY_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             key_sel,
    output logic             busy,
    output logic             ready,
    output logic             hit,
    output logic             cur_sel,
    output logic             ks_d_tk,
    output logic             ks_load,
    output logic [3:0]       ks_round,
    input  logic [KEY_W-1:0] ks_out,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid,
    output logic             rk_err
);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

    localparam logic [3:0] LAST_RK = 4'(NUM_RK - 1);
    localparam logic [4:0] NUM_RK5 = 5'(NUM_RK);

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             hit_q, hit_d;
    logic             sel_q, sel_d;
    logic             load_q, load_d;
    logic [3:0]       round_q, round_d;
    logic             issue;

    // Issued-round tracker: stage k holds the round driven k edges ago.
    logic [KS_LAT-1:0] pvld_q;
    logic [3:0]        pidx_q [KS_LAT];
    logic              cap_vld;
    logic [3:0]        cap_idx;
    logic              cap_last;

    logic [KEY_W-1:0] rk_mem [NUM_RK];

    logic             rd_ok;
    logic             rd_bad;
    logic [KEY_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             rd_err_q;

    assign cap_vld  = pvld_q[KS_LAT-1];
    assign cap_idx  = pidx_q[KS_LAT-1];
    assign cap_last = cap_vld && (cap_idx == LAST_RK);

    assign rd_ok  = rk_rd_en && ready_q && ({1'b0, rk_rd_idx} < NUM_RK5);
    assign rd_bad = rk_rd_en && !rd_ok;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        hit_d   = 1'b0;
        sel_d   = sel_q;
        load_d  = 1'b0;
        round_d = round_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ready_q && (key_sel == sel_q)) begin
                        hit_d = 1'b1;
                    end else begin
                        sel_d   = key_sel;
                        ready_d = 1'b0;
                        busy_d  = 1'b1;
                        load_d  = 1'b1;
                        round_d = 4'd0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                round_d = 4'd0;
                issue   = 1'b1;
                state_d = (LAST_RK == 4'd0) ? DRAIN : EXPAND;
            end
            EXPAND: begin
                round_d = round_q + 4'd1;
                issue   = 1'b1;
                if (round_d == LAST_RK) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_last) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    round_d = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            sel_q      <= 1'b0;
            load_q     <= 1'b0;
            round_q    <= 4'd0;
            pvld_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            hit_q      <= hit_d;
            sel_q      <= sel_d;
            load_q     <= load_d;
            round_q    <= round_d;
            pvld_q[0]  <= issue;
            for (int k = 1; k < KS_LAT; k++) begin
                pvld_q[k] <= pvld_q[k-1];
            end
            rd_valid_q <= rd_ok;
            rd_err_q   <= rd_bad;
            if (rd_ok) begin
                rd_data_q <= rk_mem[rk_rd_idx];
            end
        end
    end

    // Buffer and index pipe carry no reset; ready=0 marks the contents stale.
    always_ff @(posedge clk) begin
        pidx_q[0] <= round_d;
        for (int k = 1; k < KS_LAT; k++) begin
            pidx_q[k] <= pidx_q[k-1];
        end
        if (cap_vld) begin
            rk_mem[cap_idx] <= ks_out;
        end
    end

    assign busy        = busy_q;
    assign ready       = ready_q;
    assign hit         = hit_q;
    assign cur_sel     = sel_q;
    assign ks_d_tk     = sel_q;
    assign ks_load     = load_q;
    assign ks_round    = round_q;
    assign rk_rd_data  = rd_data_q;
    assign rk_rd_valid = rd_valid_q;
    assign rk_err      = rd_err_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: a stand-in expander plus a cycle-count model of the
// sequencer, compared against the DUT on every falling edge.
module tb_key_sched_ctrl;

    localparam int NUM_RK = 15;
    localparam int KS_LAT = 1;
    localparam int KEY_W  = 128;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             key_sel = 1'b0;
    logic             rk_rd_en = 1'b0;
    logic [3:0]       rk_rd_idx = 4'd0;
    logic             busy, ready, hit, cur_sel, ks_d_tk, ks_load;
    logic [3:0]       ks_round;
    logic [KEY_W-1:0] ks_out;
    logic [KEY_W-1:0] rk_rd_data;
    logic             rk_rd_valid, rk_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_sched_ctrl #(.NUM_RK(NUM_RK), .KS_LAT(KS_LAT), .KEY_W(KEY_W)) dut (
        .clk(clk), .rst(rst), .start(start), .key_sel(key_sel),
        .busy(busy), .ready(ready), .hit(hit), .cur_sel(cur_sel),
        .ks_d_tk(ks_d_tk), .ks_load(ks_load), .ks_round(ks_round),
        .ks_out(ks_out), .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
        .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid), .rk_err(rk_err)
    );

    // Stand-in expander: round key r of the selected key, distinct per round.
    function automatic logic [127:0] rk_val(input logic sel, input logic [3:0] r);
        logic [31:0] w;
        if (!sel && r == 4'd0) return 128'h31415926535897932384626433832795;
        if (!sel && r == 4'd1) return 128'h02884197169399375105820974944592;
        if (sel && r == 4'd0)  return 128'h27182818284590452353602874713526;
        if (sel && r == 4'd1)  return 128'h62497757247093699959574966967627;
        w = {3'b000, sel, r, 24'h5EED00} ^ (32'(r) * 32'h9E3779B1);
        return {w, ~w, w ^ 32'h12345678, w[15:0], w[31:16]};
    endfunction

    assign ks_out = rk_val(ks_d_tk, ks_round);

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a request is a count of edges since acceptance; the set
    // becomes available NUM_RK+KS_LAT edges later.
    logic         m_busy = 1'b0;
    logic         m_ready = 1'b0;
    logic         m_sel = 1'b0;
    int           m_k = 0;
    logic         e_hit = 1'b0;
    logic         e_valid = 1'b0;
    logic         e_err = 1'b0;
    logic [127:0] e_data = '0;
    logic [127:0] m_buf [16];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_busy = 1'b0; m_ready = 1'b0; m_sel = 1'b0; m_k = 0;
                e_hit = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_data = '0;
            end else begin
                e_valid = 1'b0;
                e_err   = 1'b0;
                e_hit   = 1'b0;
                if (rk_rd_en) begin
                    if (m_ready && int'(rk_rd_idx) < NUM_RK) begin
                        e_valid = 1'b1;
                        e_data  = m_buf[rk_rd_idx];
                    end else begin
                        e_err = 1'b1;
                    end
                end
                if (m_busy) begin
                    m_k++;
                    if (m_k == NUM_RK + KS_LAT) begin
                        m_busy  = 1'b0;
                        m_ready = 1'b1;
                        for (int r = 0; r < NUM_RK; r++) m_buf[r] = rk_val(m_sel, 4'(r));
                    end
                end else if (start) begin
                    if (m_ready && key_sel == m_sel) begin
                        e_hit = 1'b1;
                    end else begin
                        m_sel   = key_sel;
                        m_ready = 1'b0;
                        m_busy  = 1'b1;
                        m_k     = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 128'(busy), 128'(m_busy));
            chk("ready", 128'(ready), 128'(m_ready));
            chk("hit", 128'(hit), 128'(e_hit));
            chk("cur_sel", 128'(cur_sel), 128'(m_sel));
            chk("ks_d_tk", 128'(ks_d_tk), 128'(m_sel));
            chk("ks_load", 128'(ks_load), 128'(m_busy && m_k == 0));
            chk("ks_round", 128'(ks_round), 128'((m_busy && m_k > 0) ? m_k - 1 : 0));
            chk("rd_valid", 128'(rk_rd_valid), 128'(e_valid));
            chk("rd_err", 128'(rk_err), 128'(e_err));
            chk("rd_data", rk_rd_data, e_data);
        end
    end

    task automatic run_expand(input logic sel, input bit hold, output int lat, output int loads);
        start   = 1'b1;
        key_sel = sel;
        @(negedge clk);
        loads = int'(ks_load);
        if (!hold) start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            loads += int'(ks_load);
            if (ready && lat < 0) lat = i;
            if (!hold && lat >= 0) break;
            if (hold && i >= 20) break;
        end
        start = 1'b0;
    endtask

    task automatic read_one(input logic [3:0] idx);
        rk_rd_en  = 1'b1;
        rk_rd_idx = idx;
        @(negedge clk);
        rk_rd_en  = 1'b0;
    endtask

    int lat, loads;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 128'(ready), 128'(0));
        chk("rst_round", 128'(ks_round), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        run_expand(1'b0, 1'b0, lat, loads);
        chk("t1_latency", 128'(lat), 128'(16));
        chk("t1_loads", 128'(loads), 128'(1));
        chk("t1_dtk", 128'(ks_d_tk), 128'(0));

        read_one(4'd0);
        chk("t2_valid0", 128'(rk_rd_valid), 128'(1));
        chk("t2_data0", rk_rd_data, 128'h31415926535897932384626433832795);
        read_one(4'd1);
        chk("t2_data1", rk_rd_data, 128'h02884197169399375105820974944592);

        start = 1'b1; key_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("t3_hit", 128'(hit), 128'(1));
        chk("t3_noload", 128'(ks_load), 128'(0));
        chk("t3_ready", 128'(ready), 128'(1));
        run_expand(1'b1, 1'b0, lat, loads);
        chk("t3_latency", 128'(lat), 128'(16));
        read_one(4'd0);
        chk("t3_data0", rk_rd_data, 128'h27182818284590452353602874713526);
        read_one(4'd1);
        chk("t3_data1", rk_rd_data, 128'h62497757247093699959574966967627);

        read_one(4'd15);
        chk("t4_err15", 128'(rk_err), 128'(1));
        chk("t4_valid15", 128'(rk_rd_valid), 128'(0));
        chk("t4_hold15", rk_rd_data, 128'h62497757247093699959574966967627);
        start = 1'b1; key_sel = 1'b0;
        @(negedge clk);
        start = 1'b0;
        read_one(4'd3);
        chk("t4_err_busy", 128'(rk_err), 128'(1));
        chk("t4_hold_busy", rk_rd_data, 128'h62497757247093699959574966967627);
        for (int i = 0; i < 40 && !ready; i++) @(negedge clk);
        chk("t4_done", 128'(ready), 128'(1));

        start = 1'b1; key_sel = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && ks_round != 4'd7; i++) @(negedge clk);
        chk("t5_round7", 128'(ks_round), 128'(7));
        #2 rst = 1'b1;
        #1;
        chk("t5_async_busy", 128'(busy), 128'(0));
        chk("t5_async_ready", 128'(ready), 128'(0));
        chk("t5_async_round", 128'(ks_round), 128'(0));
        chk("t5_async_sel", 128'(cur_sel), 128'(0));
        chk("t5_async_data", rk_rd_data, 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_expand(1'b1, 1'b0, lat, loads);
        chk("t5_reexpand_loads", 128'(loads), 128'(1));
        chk("t5_latency", 128'(lat), 128'(16));

        run_expand(1'b0, 1'b1, lat, loads);
        chk("t6_latency", 128'(lat), 128'(16));
        chk("t6_loads", 128'(loads), 128'(1));

        for (int c = 0; c < 800; c++) begin
            start     = ($urandom_range(0, 3) == 0);
            key_sel   = 1'($urandom_range(0, 1));
            rk_rd_en  = 1'($urandom_range(0, 1));
            rk_rd_idx = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        start    = 1'b0;
        rk_rd_en = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
